// File: rtl/board_move_reader_if.sv
// Bundle between the board move reader, the eight column move FIFOs and the downstream consumer.
// Ports: col_done/col_empty/col_data are the FIFO status and show-ahead heads; col_rden is the pop strobes;
// out_data/out_valid/out_ready is the forwarded move stream; out_col (column tag) exists only with COL_TAG_EN.
interface board_move_reader_if #(
  parameter int NCOL   = 8,
  parameter int WORD_W = 160
);
  logic [NCOL-1:0]        col_done;
  logic [NCOL-1:0]        col_empty;
  logic [NCOL*WORD_W-1:0] col_data;
  logic [NCOL-1:0]        col_rden;
  logic [WORD_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_ready;
`ifdef COL_TAG_EN
  logic [$clog2(NCOL)-1:0] out_col;
`endif

  // Reader side: consumes FIFO status, drives pops and the output stream.
  modport master (
    input  col_done, col_empty, col_data, out_ready,
    output col_rden, out_data, out_valid
`ifdef COL_TAG_EN
    , output out_col
`endif
  );

  // Environment side: FIFOs and downstream consumer.
  modport slave (
    output col_done, col_empty, col_data, out_ready,
    input  col_rden, out_data, out_valid
`ifdef COL_TAG_EN
    , input out_col
`endif
  );
endinterface

// File: rtl/board_move_reader.sv
// Drain engine: visits the column move FIFOs round-robin, pops up to MAX_BURST words per visit and
// forwards them through a single registered valid/ready output; done once all columns are finished and drained.
// Ports: clk, reset (sync, active-high), start pulse, bus (FIFO side + output stream), busy, done, word_count.
// Optional macro COL_TAG_EN adds bus.out_col, the source column of out_data, registered with it.
module board_move_reader #(
  parameter int NCOL      = 8,
  parameter int WORD_W    = 160,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  board_move_reader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     word_count
);
  localparam int PTR_W = $clog2(NCOL);

  typedef enum logic [1:0] {IDLE, SCAN, POP, DONE} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt, ptr_inc;
  logic [7:0]        burst, burst_nxt;
  logic              can_load, pop, head_empty, all_clear, clr_round;
  logic [NCOL-1:0]   rden;
  logic [WORD_W-1:0] head_dat;
  logic [WORD_W-1:0] out_data_q;
  logic              out_valid_q;

  assign ptr_inc    = (ptr == PTR_W'(NCOL - 1)) ? '0 : ptr + 1'b1;
  assign head_empty = bus.col_empty[ptr];
  assign head_dat   = bus.col_data[int'(ptr) * WORD_W +: WORD_W];
  assign can_load   = ~out_valid_q | bus.out_ready;
  assign all_clear  = (&bus.col_done) & (&bus.col_empty);

  // Pop is gated by reset so a reset landing mid-burst never drains one more word.
  assign pop = (state == POP) & ~reset & ~head_empty & can_load & (burst < 8'(MAX_BURST));

  always_comb begin
    rden      = '0;
    rden[ptr] = pop;
  end
  assign bus.col_rden = rden;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    burst_nxt = burst;
    clr_round = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SCAN;
          ptr_nxt   = '0;
          clr_round = 1'b1;
        end
      end
      SCAN: begin
        if (!head_empty) begin
          burst_nxt = '0;
          state_nxt = POP;
        end else if (all_clear) begin
          state_nxt = DONE;
        end else begin
          ptr_nxt = ptr_inc;
        end
      end
      POP: begin
        if (pop) burst_nxt = burst + 8'd1;
        // Leave on an empty head, or right after the pop that uses up this visit's quota.
        if (head_empty || (burst_nxt >= 8'(MAX_BURST))) begin
          state_nxt = SCAN;
          ptr_nxt   = ptr_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      burst       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      word_count  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      burst <= burst_nxt;
      if (pop) begin
        out_data_q  <= head_dat;
        out_valid_q <= 1'b1;
        if (word_count != '1) word_count <= word_count + 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (clr_round) word_count <= '0;
    end
  end

`ifdef COL_TAG_EN
  logic [PTR_W-1:0] out_col_q;
  always_ff @(posedge clk) begin
    if (reset)    out_col_q <= '0;
    else if (pop) out_col_q <= ptr;
  end
  assign bus.out_col = out_col_q;
`endif

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  assign busy = (state == SCAN) || (state == POP);
  // done waits for the output register to drain so the last word is really gone.
  assign done = (state == DONE) && !out_valid_q;
endmodule

// File: tb/tb_board_move_reader.sv
module tb_board_move_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] word_count;

  board_move_reader_if bus();

  board_move_reader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int onehot_bad = 0;

  logic [159:0] mem [8][64];
  int hd[8];
  int tl[8];
  logic [7:0] rd;

  int           pop_col[$];
  int           pop_cyc[$];
  logic [159:0] rx_dat[$];
  int           rx_col[$];

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] mkw(input int c, input int i);
    return {8'(c), 8'(i), {9{16'hA5C3}}};
  endfunction

  task automatic fifo_refresh;
    for (int c = 0; c < 8; c++) begin
      bus.col_empty[c] = (hd[c] == tl[c]);
      bus.col_data[c*160 +: 160] = mem[c][hd[c]];
    end
  endtask

  task automatic fifo_clear;
    for (int c = 0; c < 8; c++) begin
      hd[c] = 0;
      tl[c] = 0;
      for (int k = 0; k < 64; k++) mem[c][k] = '0;
    end
    fifo_refresh();
  endtask

  task automatic fifo_push(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      mem[c][tl[c]] = mkw(c, k);
      tl[c]++;
    end
    fifo_refresh();
  endtask

  task automatic clear_logs;
    pop_col.delete(); pop_cyc.delete(); rx_dat.delete(); rx_col.delete();
    onehot_bad = 0;
  endtask

  // One clock: record pops/transfers just before the edge, then apply pops to the FIFO model.
  task automatic tick;
    #1;
    rd = bus.col_rden;
    if (bus.out_valid && bus.out_ready) begin
      rx_dat.push_back(bus.out_data);
`ifdef COL_TAG_EN
      rx_col.push_back(int'(bus.out_col));
`endif
    end
    if (rd != 8'h00) begin
      pop_cyc.push_back(cyc);
      if ($countones(rd) != 1) onehot_bad++;
      for (int c = 0; c < 8; c++) if (rd[c]) pop_col.push_back(c);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 8; c++) if (rd[c] && hd[c] != tl[c]) hd[c]++;
    fifo_refresh();
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_start;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done && n < limit) begin tick(); n++; end
    check_eq(tag, 160'(done), 160'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int exp_c[$];
    int exp_i[$];
    reset = 1'b1; start = 1'b0;
    bus.col_done = 8'hFF; bus.out_ready = 1'b1;
    fifo_clear();

    // Reset state, then an empty board finishes straight away.
    reset = 1'b1; tick(); tick();
    check_eq("rst_busy", 160'(busy), 160'd0);
    check_eq("rst_done", 160'(done), 160'd0);
    check_eq("rst_valid", 160'(bus.out_valid), 160'd0);
    check_eq("rst_data", bus.out_data, 160'd0);
    check_eq("rst_count", 160'(word_count), 160'd0);
    check_eq("rst_rden", 160'(bus.col_rden), 160'd0);
    reset = 1'b0; clear_logs();
    pulse_start();
    wait_done("empty_done", 8);
    check_eq("empty_count", 160'(word_count), 160'd0);
    check_eq("empty_pops", 160'(pop_col.size()), 160'd0);

    // Column 3 holds A,B,C.
    fifo_clear(); bus.col_done = 8'h00; fifo_push(3, 3);
    do_reset();
    pulse_start();
    repeat (15) tick();
    check_eq("c3_pops", 160'(pop_col.size()), 160'd3);
    for (int i = 0; i < pop_col.size() && i < 3; i++) begin
      check_eq("c3_col", 160'(pop_col[i]), 160'd3);
      check_eq("c3_cyc", 160'(pop_cyc[i] - pop_cyc[0]), 160'(i));
    end
    check_eq("c3_rx", 160'(rx_dat.size()), 160'd3);
    for (int i = 0; i < rx_dat.size() && i < 3; i++) check_eq("c3_word", rx_dat[i], mkw(3, i));
    check_eq("c3_count", 160'(word_count), 160'd3);
    check_eq("c3_notdone", 160'(done), 160'd0);
    check_eq("c3_onehot", 160'(onehot_bad), 160'd0);
    bus.col_done = 8'hFF;
    wait_done("c3_done", 20);

    // Columns 0 and 5, 20 words each: burst cap interleaves them.
    fifo_clear(); bus.col_done = 8'hFF; fifo_push(0, 20); fifo_push(5, 20);
    do_reset();
    pulse_start();
    wait_done("burst_done", 300);
    exp_c.delete(); exp_i.delete();
    for (int k = 0; k < 16; k++) begin exp_c.push_back(0); exp_i.push_back(k); end
    for (int k = 0; k < 16; k++) begin exp_c.push_back(5); exp_i.push_back(k); end
    for (int k = 16; k < 20; k++) begin exp_c.push_back(0); exp_i.push_back(k); end
    for (int k = 16; k < 20; k++) begin exp_c.push_back(5); exp_i.push_back(k); end
    check_eq("burst_pops", 160'(pop_col.size()), 160'd40);
    check_eq("burst_rx", 160'(rx_dat.size()), 160'd40);
    for (int i = 0; i < 40 && i < pop_col.size(); i++) check_eq("burst_col", 160'(pop_col[i]), 160'(exp_c[i]));
    for (int i = 0; i < 40 && i < rx_dat.size(); i++) check_eq("burst_word", rx_dat[i], mkw(exp_c[i], exp_i[i]));
`ifdef COL_TAG_EN
    for (int i = 0; i < 40 && i < rx_col.size(); i++) check_eq("burst_tag", 160'(rx_col[i]), 160'(exp_c[i]));
`endif
    check_eq("burst_count", 160'(word_count), 160'd40);
    check_eq("burst_onehot", 160'(onehot_bad), 160'd0);

    // Back-pressure on column 2.
    fifo_clear(); bus.col_done = 8'h00; fifo_push(2, 6);
    do_reset();
    bus.out_ready = 1'b0;
    pulse_start();
    n = 0;
    while (pop_col.size() == 0 && n < 20) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("stall_data", bus.out_data, mkw(2, 0));
      check_eq("stall_valid", 160'(bus.out_valid), 160'd1);
      check_eq("stall_rden", 160'(bus.col_rden), 160'd0);
    end
    check_eq("stall_pops", 160'(pop_col.size()), 160'd1);
    bus.out_ready = 1'b1;
    repeat (12) tick();
    check_eq("stall_total", 160'(pop_col.size()), 160'd6);
    for (int i = 1; i < pop_cyc.size(); i++) check_eq("stall_rate", 160'(pop_cyc[i] - pop_cyc[1]), 160'(i - 1));
    check_eq("stall_rx", 160'(rx_dat.size()), 160'd6);
    for (int i = 0; i < rx_dat.size() && i < 6; i++) check_eq("stall_word", rx_dat[i], mkw(2, i));
    bus.col_done = 8'hFF;
    wait_done("stall_done", 20);

    // Reset in the middle of a burst on column 6.
    fifo_clear(); bus.col_done = 8'h00; fifo_push(6, 10);
    do_reset();
    pulse_start();
    n = 0;
    while (pop_col.size() < 3 && n < 30) begin tick(); n++; end
    check_eq("mid_count_pre", 160'(word_count), 160'd3);
    reset = 1'b1;
    tick();
    check_eq("mid_rden", 160'(bus.col_rden), 160'd0);
    check_eq("mid_valid", 160'(bus.out_valid), 160'd0);
    check_eq("mid_busy", 160'(busy), 160'd0);
    check_eq("mid_count", 160'(word_count), 160'd0);
    check_eq("mid_fifo", 160'(hd[6]), 160'd3);
    reset = 1'b0;
    repeat (3) tick();
    check_eq("mid_nopop", 160'(pop_col.size()), 160'd3);
    check_eq("mid_idle", 160'(busy), 160'd0);

    // start while busy is ignored; start in DONE restarts the round.
    fifo_clear(); bus.col_done = 8'h00; fifo_push(1, 2);
    do_reset();
    pulse_start();
    repeat (10) tick();
    check_eq("busy_count", 160'(word_count), 160'd2);
    check_eq("busy_busy", 160'(busy), 160'd1);
    pulse_start();
    tick();
    check_eq("busy_ignored", 160'(word_count), 160'd2);
    check_eq("busy_still", 160'(busy), 160'd1);
    bus.col_done = 8'hFF;
    wait_done("restart_done1", 20);
    check_eq("restart_count1", 160'(word_count), 160'd2);
    pulse_start();
    check_eq("restart_drop", 160'(done), 160'd0);
    check_eq("restart_busy", 160'(busy), 160'd1);
    check_eq("restart_clr", 160'(word_count), 160'd0);
    fifo_push(4, 1);
    wait_done("restart_done2", 30);
    check_eq("restart_count2", 160'(word_count), 160'd1);
    if (rx_dat.size() > 0) check_eq("restart_word", rx_dat[rx_dat.size()-1], mkw(4, 0));
    else check_eq("restart_rx", 160'(rx_dat.size()), 160'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_move_reader.md
Name: board_move_reader

Overview:
Board-level drain engine at the read end of the eight column move FIFOs. It sequences the columns round-robin and pops each column's 160-bit move words with that column's read enable. It forwards the words on a single valid/ready stream to the search/host logic. It asserts done once every column has finished generating and every column FIFO, plus its own output register, is empty.

Parameters:
NCOL, 8, number of column FIFOs drained; column index is 3 bits.
WORD_W, 160, width of one column FIFO entry.
MAX_BURST, 16, maximum words popped from one column per visit (fairness cap); range 1..255.
CNT_W, 16, width of word_count.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a drain round
col_done  input  8  per-column done flags; bit x = column x
col_empty  input  8  per-column FIFO empty flags
col_data  input  1280  show-ahead FIFO heads; column x on bits [160x+159:160x]
col_rden  output  8  per-column pop strobes, at most one bit high
out_data  output  160  registered move word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts out_data this cycle
busy  output  1  round in progress (state not IDLE/DONE)
done  output  1  round complete, held until start or reset
word_count  output  16  words forwarded this round, saturating

Behaviour:
- Column FIFOs are show-ahead. col_data slice x is valid whenever col_empty[x]=0. A col_rden[x] pulse pops it, and the next head appears the following cycle.
- Reset (synchronous, active-high; overrides everything, including mid-round): state=IDLE, ptr=0, burst=0, col_rden=0, out_valid=0, out_data=0, busy=0, done=0, word_count=0.
- Output register accept: can_load = ~out_valid | out_ready.
- A word transfers downstream on a cycle where out_valid & out_ready.
- States: IDLE, SCAN, POP, DONE.
- IDLE:
  - On start: ptr=0, word_count=0, done=0, go to SCAN.
  - Otherwise stay.
- SCAN (one column examined per cycle):
  - If col_empty[ptr]=0: burst=0, go to POP.
  - Else if &col_done & &col_empty: go to DONE.
  - Else ptr=ptr+1, wrapping 7 to 0.
- POP:
  - col_rden[ptr] is combinational: col_rden[ptr] = ~col_empty[ptr] & can_load & (burst<MAX_BURST).
  - On a pop: out_data<=col_data[ptr], out_valid<=1, burst++, word_count++ (saturates at 0xFFFF, no wrap).
  - Otherwise, if out_valid & out_ready, out_valid<=0.
  - Exit to SCAN with ptr+1 when col_empty[ptr]=1, or when burst reaches MAX_BURST after the last pop.
- Back-pressure: when can_load=0 no column is popped and out_data/out_valid hold. A full-rate pop and accept every cycle is supported; throughput is one word per cycle within a burst.
- Latency: a word at a column head that is already in POP reaches out_data one cycle after its col_rden pulse.
- DONE:
  - done=1 only once out_valid=0. If out_valid is still 1 on entry, done rises on the cycle after the final word transfers.
  - busy=0 in DONE.
  - start in DONE restarts the round: clears done and word_count, goes to SCAN with ptr=0.
- start while busy=1 is ignored.
- col_done that deasserts mid-round (new generation) simply keeps the engine in SCAN.
- Simultaneous start and reset: reset wins.

Optional Feature:
COL_TAG_EN
- Defined: adds output out_col (3 bits). It is registered alongside out_data with the ptr value of the popped column, and resets to 0.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
- Reset with col_empty=8'hFF, col_done=8'hFF, then start -> DONE within 9 cycles, done=1, word_count=0, col_rden never high.
- Column 3 holds words A,B,C, others empty, out_ready=1, then all done -> col_rden=8'h08 on 3 consecutive cycles; out_data A,B,C in order; word_count=3; done=1 after C.
- Columns 0 and 5 each hold 20 words, MAX_BURST=16 -> pops in order col0 x16, col5 x16, col0 x4, col5 x4; word_count=40; with COL_TAG_EN, out_col follows 0,5,0,5 blocks.
- out_ready held low 5 cycles with col2 non-empty -> exactly one pop, out_data stable, col_rden=0 while stalled; release -> one word per cycle resumes.
- Reset asserted mid-burst on col6 -> next cycle col_rden=0, out_valid=0, busy=0, word_count=0, state IDLE; the FIFO is not popped further.
- Start pulse while busy=1 -> ignored, word_count not cleared; start in DONE -> done drops next cycle, new round counts from 0.
